mem_byte_sequencer: RTL and testbench
=====================================

// Module: mem_byte_sequencer
// PURPOSE
//  Sequences RISC-V loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) onto the byte-wide synchronous RAM.
//  Splits each access into 1/2/4 single-byte RAM cycles, little-endian. Assembles and sign/zero-extends load data.
//  Rejects bad funct3, misaligned and out-of-range accesses before any RAM cycle. Sits between the CPU memory stage and the RAM.
// PARAMETERS
//  DEPTH_BYTES  8192  RAM size in bytes; legal byte addresses are 0..DEPTH_BYTES-1
// PORTS
//  clk               in   1   single clock, all logic on posedge
//  reset             in   1   synchronous, active-high
//  req               in   1   access request; accepted only when ready=1
//  ready             out  1   1 in IDLE only
//  we                in   1   1=store, 0=load; sampled at accept
//  funct3            in   3   RISC-V width/sign code; sampled at accept
//  addr              in   32  byte address; sampled at accept
//  store_data        in   32  store source, low bytes used; sampled at accept
//  done              out  1   one-cycle completion pulse
//  load_data         out  32  extended load result; valid from done, held until next accept
//  error             out  2   00 ok, 01 misaligned, 10 out of range, 11 bad funct3; valid with done
//  mem_address       out  32  RAM byte address
//  mem_write_data    out  8   RAM write byte
//  mem_write_enable  out  1   RAM write strobe
//  mem_read_data     in   8   RAM read byte; 1-cycle latency after mem_address
// BEHAVIOUR
//  Reset: state IDLE; ready=1, done=0, load_data=0, error=00, mem_write_enable=0, mem_address=0, mem_write_data=0.
//  Reset mid-operation: IDLE next cycle, strobe low, nothing restored (bytes already written stay written).
//  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. 011/110/111 are illegal for loads. For stores only 000/001/010 are legal.
//  n = 1/2/4 bytes. Accept = req&&ready (cycle 0). Request held while busy is ignored until IDLE.
//  Checks at accept, in priority: bad funct3 > misaligned (H: addr[0]; W: addr[1:0]!=0) > range.
//  Range fault when addr+n-1 >= DEPTH_BYTES. Compute in 33 bits so 0xFFFFFFFF does not wrap.
//  Fault: FAULT state in cycle 1, done=1 with error code, no RAM cycle, load_data=0.
//  FSM: IDLE -> ACCESS (index i=0..n-1) -> [CAPTURE, loads only] -> DONE -> IDLE. FAULT -> IDLE.
//  ACCESS cycle k+1 (k=0..n-1): mem_address=addr+k. Stores also drive mem_write_data=store_data[8k+7:8k] and mem_write_enable=1.
//  Load byte k is taken from mem_read_data in cycle k+2, into result[8k+7:8k]. CAPTURE takes the last byte.
//  Outside ACCESS: mem_address=0, mem_write_enable=0.
//  Store: done in cycle n+1. Load: done in cycle n+2, load_data updated in the same cycle. Sign from bit 7 (B) or bit 15 (H). BU/HU zero-extend.
//  Stores leave load_data=0 and error=00. ready returns 1 in the cycle after DONE/FAULT; back-to-back accept is allowed then.
// STRUCTURE
//  Package mem_ctrl_pkg: funct3 constants, error codes, state enum.
//  Sub-module load_extender (combinational): takes assembled bytes, funct3 -> 32-bit extended result.
// TESTING
//  SW 0x11223344 @0x100: cycles 1-4 write 44,33,22,11 to 0x100..0x103, done cycle 5. Then LW @0x100 -> 0x11223344, done cycle 6.
//  SB 0x80 @0x203. LB @0x203 -> 0xFFFFFF80 (done cycle 3). LBU -> 0x00000080. LHU @0x202 with byte 0x202=0x01 -> 0x00008001.
//  LH @0x101 -> error=01, done cycle 1, mem_write_enable never 1. funct3=011 @0x101 -> error=11 (priority).
//  LW @0x1FFC ok. LW @0x2000 -> 10. LH @0x1FFE ok. LW @0xFFFFFFFC -> 10.
//  SW @0x300: reset high in cycle 3 -> strobe 0 in cycle 4, ready=1. Bytes 0x300/0x301 written; 0x302/0x303 unchanged.
//  req held high from cycle 0: second access accepted only in the cycle after done. Exactly 2 dones; store fields changed while busy are ignored.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-wide memory sequencer: funct3 codes,
// error codes, FSM state encodings and small decode helpers.
package mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ACCESS  = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_DONE    = 3'd3;
    localparam state_t ST_FAULT   = 3'd4;

    // Stores only accept the signed-width codes; loads also take BU/HU.
    function automatic logic f3_legal(input logic is_store,
                                      input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Index of the last byte (n-1) for a legal funct3.
    function automatic logic [1:0] f3_last(input logic [2:0] f3);
        return (f3[1:0] == 2'b10) ? 2'd3 : {1'b0, f3[0]};
    endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational sign/zero extension of assembled little-endian load bytes.
// Ports: funct3 (width/sign code), data_i (raw bytes), result_o (extended).
module load_extender
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = data_i;
        case (funct3)
            F3_B:    result_o = {{24{data_i[7]}}, data_i[7:0]};
            F3_H:    result_o = {{16{data_i[15]}}, data_i[15:0]};
            F3_BU:   result_o = {24'h0, data_i[7:0]};
            F3_HU:   result_o = {16'h0, data_i[15:0]};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Splits RISC-V loads/stores into single-byte RAM cycles (little-endian),
// checks legality up front and extends load results.
// Ports: CPU side req/ready/we/funct3/addr/store_data/done/load_data/error;
//        RAM side mem_address/mem_write_data/mem_write_enable/mem_read_data.
module mem_byte_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH_BYTES = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  error,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_write_data,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_read_data
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] bytes_q, bytes_d;
    logic [31:0] load_q, load_d;
    logic [1:0]  err_q, err_d;

    logic        accept;
    logic [1:0]  req_last;
    logic        req_bad;
    logic        req_mis;
    logic        req_range;
    logic [32:0] req_end;
    logic [31:0] cap_bytes;
    logic [31:0] ext_result;

    assign accept   = req && (state_q == ST_IDLE);
    assign req_last = f3_last(funct3);
    assign req_bad  = !f3_legal(we, funct3);
    assign req_mis  = ((funct3[1:0] == 2'b01) && addr[0])
                   || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    // 33-bit sum keeps addresses near 0xFFFFFFFF from wrapping into range.
    assign req_end   = {1'b0, addr} + {31'b0, req_last};
    assign req_range = req_end >= 33'(DEPTH_BYTES);

    // Final byte arrives in CAPTURE; merge it before extension.
    always_comb begin
        cap_bytes = bytes_q;
        cap_bytes[{last_q, 3'b000} +: 8] = mem_read_data;
    end

    load_extender u_ext (
        .funct3   (f3_q),
        .data_i   (cap_bytes),
        .result_o (ext_result)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bytes_d = bytes_q;
        load_d  = load_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d   = 2'd0;
                    last_d  = req_last;
                    we_d    = we;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = store_data;
                    bytes_d = 32'h0;
                    load_d  = 32'h0;
                    err_d   = ERR_OK;
                    state_d = ST_FAULT;
                    if (req_bad)        err_d = ERR_FUNCT3;
                    else if (req_mis)   err_d = ERR_MISALIGN;
                    else if (req_range) err_d = ERR_RANGE;
                    else                state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Read data lags the address by one cycle: byte i-1 lands now.
                if (!we_q && (idx_q != 2'd0))
                    bytes_d[{idx_q - 2'd1, 3'b000} +: 8] = mem_read_data;
                if (idx_q == last_q)
                    state_d = we_q ? ST_DONE : ST_CAPTURE;
                else
                    idx_d = idx_q + 2'd1;
            end
            ST_CAPTURE: begin
                bytes_d = cap_bytes;
                load_d  = ext_result;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            bytes_q <= 32'h0;
            load_q  <= 32'h0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bytes_q <= bytes_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE) || (state_q == ST_FAULT);
    assign load_data = load_q;
    assign error     = err_q;

    // Strobe is also gated by reset so an aborting store never writes
    // the byte addressed in the cycle reset is raised.
    always_comb begin
        mem_address      = 32'h0;
        mem_write_data   = 8'h0;
        mem_write_enable = 1'b0;
        if (state_q == ST_ACCESS) begin
            mem_address = addr_q + {30'b0, idx_q};
            if (we_q) begin
                mem_write_data   = wdata_q[{idx_q, 3'b000} +: 8];
                mem_write_enable = !reset;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a byte-wide registered RAM.
module tb_mem_byte_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        ready;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  error;
    logic [31:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic [7:0]  mem_read_data;

    logic [7:0]  ram [0:8191];

    int n_chk = 0;
    int n_pass = 0;

    int          lat;
    logic [31:0] ld;
    logic [1:0]  er;
    int          nw;
    logic [31:0] wa [0:7];
    logic [7:0]  wd [0:7];

    always #5 clk = ~clk;

    mem_byte_sequencer #(.DEPTH_BYTES(8192)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .ready            (ready),
        .we               (we),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .done             (done),
        .load_data        (load_data),
        .error            (error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_address[12:0]] <= mem_write_data;
        mem_read_data <= ram[mem_address[12:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic run(input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        we = w; funct3 = f; addr = a; store_data = sd; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; ld = 32'hx; er = 2'bx; nw = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_write_enable) begin
                if (nw < 8) begin
                    wa[nw] = mem_address;
                    wd[nw] = mem_write_data;
                end
                nw++;
            end
            if (done) begin
                lat = c; ld = load_data; er = error;
                break;
            end
        end
    endtask

    initial begin
        int acc, ndone, acc2_cyc, d1_cyc, d2_cyc;
        logic drop;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_we", 32'(mem_write_enable), 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", 32'(mem_write_data), 32'h0);

        run(1'b1, 3'b010, 32'h100, 32'h11223344);
        chk("sw_lat", 32'(lat), 32'd5);
        chk("sw_nw", 32'(nw), 32'd4);
        chk("sw_addrs", {wa[0][7:0], wa[1][7:0], wa[2][7:0], wa[3][7:0]},
            32'h00010203);
        chk("sw_addr_hi", wa[3], 32'h103);
        chk("sw_bytes", {wd[0], wd[1], wd[2], wd[3]}, 32'h44332211);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_load", ld, 32'h0);

        run(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_lat", 32'(lat), 32'd6);
        chk("lw_data", ld, 32'h11223344);

        run(1'b1, 3'b000, 32'h203, 32'h00000080);
        chk("sb_lat", 32'(lat), 32'd2);
        run(1'b0, 3'b000, 32'h203, 32'h0);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_data", ld, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h203, 32'h0);
        chk("lbu_data", ld, 32'h00000080);
        run(1'b1, 3'b000, 32'h202, 32'h00000001);
        run(1'b0, 3'b101, 32'h202, 32'h0);
        chk("lhu_lat", 32'(lat), 32'd4);
        chk("lhu_data", ld, 32'h00008001);
        run(1'b0, 3'b001, 32'h202, 32'h0);
        chk("lh_data", ld, 32'hFFFF8001);

        run(1'b0, 3'b001, 32'h101, 32'h0);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_load", ld, 32'h0);
        run(1'b1, 3'b010, 32'h102, 32'hFFFFFFFF);
        chk("sw_mis_err", 32'(er), 32'd1);
        chk("sw_mis_nw", 32'(nw), 32'd0);
        run(1'b0, 3'b011, 32'h101, 32'h0);
        chk("f3_prio", 32'(er), 32'd3);
        run(1'b1, 3'b100, 32'h100, 32'h0);
        chk("st_bu_err", 32'(er), 32'd3);
        chk("st_bu_nw", 32'(nw), 32'd0);

        run(1'b0, 3'b010, 32'h1FFC, 32'h0);
        chk("lw_top_err", 32'(er), 32'd0);
        chk("lw_top_lat", 32'(lat), 32'd6);
        run(1'b0, 3'b010, 32'h2000, 32'h0);
        chk("lw_oor", 32'(er), 32'd2);
        run(1'b0, 3'b001, 32'h1FFE, 32'h0);
        chk("lh_top_err", 32'(er), 32'd0);
        run(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0);
        chk("lw_wrap", 32'(er), 32'd2);
        run(1'b0, 3'b100, 32'h1FFF, 32'h0);
        chk("lbu_last_err", 32'(er), 32'd0);

        run(1'b1, 3'b010, 32'h300, 32'hAABBCCDD);
        @(negedge clk);
        we = 1'b1; funct3 = 3'b010; addr = 32'h300;
        store_data = 32'h11223344; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_we", 32'(mem_write_enable), 32'd0);
        chk("rst_mid_rdy", 32'(ready), 32'd1);
        run(1'b0, 3'b010, 32'h300, 32'h0);
        chk("rst_mid_mem", ld, 32'hAABB3344);

        @(negedge clk);
        we = 1'b1; funct3 = 3'b010; addr = 32'h400;
        store_data = 32'h01020304; req = 1'b1;
        acc = 0; ndone = 0; acc2_cyc = -1; d1_cyc = -1; d2_cyc = -1;
        drop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ready && req) begin
                acc++;
                if (acc == 2) begin
                    acc2_cyc = c;
                    drop = 1'b1;
                end
            end
            if (done) begin
                ndone++;
                if (ndone == 1) d1_cyc = c;
                else if (ndone == 2) d2_cyc = c;
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                addr = 32'h500;
                store_data = 32'hDEADBEEF;
            end
            if (drop) begin
                req = 1'b0;
                drop = 1'b0;
            end
            @(negedge clk);
        end
        chk("hold_done1", 32'(d1_cyc), 32'd5);
        chk("hold_acc2", 32'(acc2_cyc), 32'd6);
        chk("hold_done2", 32'(d2_cyc), 32'd11);
        chk("hold_ndone", 32'(ndone), 32'd2);
        run(1'b0, 3'b010, 32'h400, 32'h0);
        chk("hold_mem1", ld, 32'h01020304);
        run(1'b0, 3'b010, 32'h500, 32'h0);
        chk("hold_mem2", ld, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
